pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Central stall/flush sequencer for the 5-stage RV32 pipeline. It drives the hold (`NOP`) and bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers, and selects the next-PC source. It resolves load-use hazards, instruction/data memory wait states, taken branches/jumps, `mret` redirects and machine-interrupt entry. Interrupt entry uses a drain-then-redirect FSM that also captures the exception PC.

## Interface
Parameters:
- `DRAIN_CYCLES`, 3, bubbles required after fetch stops before trap redirect (covers ID, EX, MEM)
- `XLEN`, 32, PC width

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  asynchronous reset, active-high
- `imem_busy`  in  1  instruction fetch not complete this cycle
- `dmem_busy`  in  1  MEM-stage data access not complete this cycle
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID
- `id_use_rs1`, `id_use_rs2`  in  1 each  ID instruction reads rs1/rs2
- `ex_rd`  in  5  destination register in EX
- `ex_memread`  in  1  EX instruction is a load
- `ex_br_taken`  in  1  branch/jal/jalr resolved taken in EX
- `ex_mret`  in  1  `mret` in EX
- `ex_br_target`  in  XLEN  resolved target of the EX control transfer
- `ifid_pc`  in  XLEN  PC held in IF/ID
- `irq_pending`, `mie`  in  1 each  machine interrupt request and global enable
- `stall_pc`, `stall_ifid`, `stall_idex`, `stall_exmem`, `stall_memwb`  out  1 each  hold register (NOP)
- `flush_ifid`, `flush_idex`, `flush_exmem`  out  1 each  load a bubble
- `pc_sel`  out  2  0 = PC+4, 1 = branch target, 2 = trap vector, 3 = mepc
- `trap_taken`  out  1  one-cycle pulse, CSR unit performs trap entry
- `trap_epc`  out  XLEN  registered exception PC

## Operation
FSM states: RUN, DRAIN, REDIRECT.

Combinational decisions, highest priority first:
1. `dmem_busy`: assert all five stalls; no flushes; `pc_sel`=0; FSM drain counter frozen.
2. State REDIRECT:
   - `flush_ifid`, `flush_idex`, `flush_exmem`=1
   - `pc_sel`=2, `trap_taken`=1
   - next state RUN
3. `ex_br_taken` or `ex_mret`:
   - With `imem_busy`: hold PC, IF/ID, ID/EX and flush EX/MEM until fetch completes.
   - Otherwise: `pc_sel`=1 (branch) or 3 (mret); flush IF/ID and ID/EX.
   - In DRAIN: `trap_epc` <= `ex_br_target` (mret in DRAIN: epc <= `ex_br_target` as well).
4. Load-use: `ex_memread` & `ex_rd`≠0 & ((`id_use_rs1` & `id_rs1`==`ex_rd`) | (`id_use_rs2` & `id_rs2`==`ex_rd`)). Response: `stall_pc`, `stall_ifid`, `flush_idex` for one cycle.
5. `imem_busy`, or state DRAIN: `stall_pc` and `flush_ifid`.

Interrupt entry:
- Accepted in RUN when `irq_pending` & `mie` and none of rules 1, 3, 4 applies.
- On acceptance: `trap_epc` <= `ifid_pc`, drain counter <= `DRAIN_CYCLES`, state DRAIN.
- DRAIN: counter decrements each cycle `dmem_busy`=0. At 0 → REDIRECT.
- `irq_pending` deasserting during DRAIN does not abort entry.

## Timing
- Stall, flush, `pc_sel` and `trap_taken` are combinational from the current inputs and registered state. No added latency.
- Load-use costs exactly 1 bubble. Taken branch costs 2 bubbles.
- Interrupt: acceptance edge + `DRAIN_CYCLES` non-busy cycles in DRAIN + 1 REDIRECT cycle. `trap_taken` is high exactly one cycle.
- Reset (`rst` high, asynchronous):
  - state RUN, counter 0, `trap_epc`=0
  - all outputs forced low, `pc_sel`=0, regardless of inputs
- Reset mid-DRAIN/REDIRECT abandons entry; no `trap_taken`.
- Counter never underflows: transition at 0, no wrap.

## Configuration
`HAZ_PERF_CNT_EN`:
- Defined: adds 32-bit outputs `perf_stall_cycles` (cycles any stall or flush asserted) and `perf_loaduse_cnt` (load-use events).
  - Both reset to 0 and wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

## Structure
- Package `cpu_ctrl_pkg`:
  - FSM state enum
  - `pc_sel` encoding constants (`PCSEL_SEQ`, `PCSEL_BR`, `PCSEL_TRAP`, `PCSEL_MEPC`)
  - `DRAIN_CYCLES` default
- One sub-module `loaduse_detect`: pure comparator for rule 4.
- FSM and priority logic stay in the top module.

## Test plan
- `ex_memread`=1, `ex_rd`=5, `id_rs1`=5, `id_use_rs1`=1 → one cycle with `stall_pc`=`stall_ifid`=`flush_idex`=1; same with `ex_rd`=0 → no stall.
- `ex_br_taken`=1, `ex_br_target`=0x100 → `pc_sel`=1, `flush_ifid`=`flush_idex`=1 for one cycle; repeat with `imem_busy` high 3 cycles → hold and `flush_exmem` for 3 cycles, then redirect.
- `dmem_busy` high 4 cycles concurrent with load-use and branch → all five stalls for 4 cycles, no flushes; branch resolves afterwards.
- `irq_pending`=`mie`=1, `ifid_pc`=0x40 → 3 DRAIN cycles, then `trap_taken` pulse with `pc_sel`=2, `trap_epc`=0x40; with `dmem_busy` in DRAIN, entry extends by the busy cycles.
- Branch to 0x200 during DRAIN → `trap_epc`=0x200 at `trap_taken`.
- `rst` asserted in DRAIN → outputs low immediately, no `trap_taken`, state RUN after release.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: shared FSM states, pc_sel encodings and drain default for pipeline control
package cpu_ctrl_pkg;
  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_REDIRECT} hz_state_e;
  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_BR = 2'd1;
  localparam logic [1:0] PCSEL_TRAP = 2'd2;
  localparam logic [1:0] PCSEL_MEPC = 2'd3;
  localparam int DRAIN_CYCLES_DEFAULT = 3;
endpackage

// File: rtl/loaduse_detect.sv
// loaduse_detect: flags an ID-stage read of the register a load in EX is about to write
module loaduse_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_use_rs1,
  input  logic       id_use_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  output logic       hazard
);
  assign hazard = ex_memread && ex_rd != 5'd0 &&
                  ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer and drain-then-redirect interrupt entry for the 5-stage pipe.
// Optional HAZ_PERF_CNT_EN adds stall-cycle and load-use event counters.
module pipe_hazard_ctrl
  import cpu_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            imem_busy,
  input  logic            dmem_busy,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic            id_use_rs1,
  input  logic            id_use_rs2,
  input  logic [4:0]      ex_rd,
  input  logic            ex_memread,
  input  logic            ex_br_taken,
  input  logic            ex_mret,
  input  logic [XLEN-1:0] ex_br_target,
  input  logic [XLEN-1:0] ifid_pc,
  input  logic            irq_pending,
  input  logic            mie,
  output logic            stall_pc,
  output logic            stall_ifid,
  output logic            stall_idex,
  output logic            stall_exmem,
  output logic            stall_memwb,
  output logic            flush_ifid,
  output logic            flush_idex,
  output logic            flush_exmem,
  output logic [1:0]      pc_sel,
  output logic            trap_taken,
  output logic [XLEN-1:0] trap_epc
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [31:0]     perf_loaduse_cnt
`endif
);
  hz_state_e  state;
  logic [7:0] cnt;
  logic [7:0] cnt_nxt;
  logic       lu_raw;
  logic       live;
  logic       mem_hold;
  logic       redir;
  logic       ctl;
  logic       br_hold;
  logic       br_go;
  logic       lu;
  logic       fetch_hold;
  logic       accept;

  loaduse_detect u_lu (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .hazard     (lu_raw)
  );

  // Each term is exclusive of everything above it in priority; reset masks all of them.
  always_comb begin
    live       = !rst && !dmem_busy;
    mem_hold   = !rst && dmem_busy;
    redir      = live && state == ST_REDIRECT;
    ctl        = live && state != ST_REDIRECT && (ex_br_taken || ex_mret);
    br_hold    = ctl && imem_busy;
    br_go      = ctl && !imem_busy;
    lu         = live && state != ST_REDIRECT && !ctl && lu_raw;
    fetch_hold = live && state != ST_REDIRECT && !ctl && !lu && (imem_busy || state == ST_DRAIN);
    accept     = live && state == ST_RUN && irq_pending && mie && !ctl && !lu;
    cnt_nxt    = cnt - {7'd0, cnt != 8'd0};
  end

  assign stall_pc    = mem_hold || br_hold || lu || fetch_hold;
  assign stall_ifid  = mem_hold || br_hold || lu;
  assign stall_idex  = mem_hold || br_hold;
  assign stall_exmem = mem_hold;
  assign stall_memwb = mem_hold;
  assign flush_ifid  = redir || br_go || fetch_hold;
  assign flush_idex  = redir || br_go || lu;
  assign flush_exmem = redir || br_hold;
  assign trap_taken  = redir;
  assign pc_sel      = redir ? PCSEL_TRAP : br_go ? (ex_mret ? PCSEL_MEPC : PCSEL_BR) : PCSEL_SEQ;

  // A control transfer resolving during DRAIN becomes the resume point of the trap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_RUN;
      cnt      <= 8'd0;
      trap_epc <= '0;
    end else if (!dmem_busy) begin
      if (accept) begin
        trap_epc <= ifid_pc;
        cnt      <= 8'(DRAIN_CYCLES);
        state    <= ST_DRAIN;
      end
      if (state == ST_DRAIN) begin
        if (ctl) trap_epc <= ex_br_target;
        cnt <= cnt_nxt;
        if (cnt_nxt == 8'd0) state <= ST_REDIRECT;
      end
      if (state == ST_REDIRECT) state <= ST_RUN;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cycles <= '0;
      perf_loaduse_cnt  <= '0;
    end else begin
      if (stall_pc || stall_ifid || stall_idex || stall_exmem || stall_memwb ||
          flush_ifid || flush_idex || flush_exmem)
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (lu) perf_loaduse_cnt <= perf_loaduse_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: vector table, interrupt/reset sequences and randomized run against a rule-level model
module tb_pipe_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_busy, dmem_busy;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, ex_mret;
  logic [31:0] ex_br_target, ifid_pc;
  logic        irq_pending, mie;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic        flush_ifid, flush_idex, flush_exmem, trap_taken;
  logic [1:0]  pc_sel;
  logic [31:0] trap_epc;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_loaduse_cnt;
`endif
  logic [10:0] obs;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst), .imem_busy(imem_busy), .dmem_busy(dmem_busy),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_memread(ex_memread), .ex_br_taken(ex_br_taken), .ex_mret(ex_mret),
    .ex_br_target(ex_br_target), .ifid_pc(ifid_pc), .irq_pending(irq_pending), .mie(mie),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .stall_memwb(stall_memwb), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .flush_exmem(flush_exmem), .pc_sel(pc_sel),
    .trap_taken(trap_taken), .trap_epc(trap_epc)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_loaduse_cnt(perf_loaduse_cnt)
`endif
  );

  assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem, stall_memwb,
                flush_ifid, flush_idex, flush_exmem, pc_sel, trap_taken};

  localparam logic [10:0] IDLE  = 11'b0;
  localparam logic [10:0] DRNO  = {5'b10000, 3'b100, 2'd0, 1'b0};
  localparam logic [10:0] REDIR = {5'b00000, 3'b111, 2'd2, 1'b1};
  localparam logic [10:0] BUSY  = {5'b11111, 3'b000, 2'd0, 1'b0};
  localparam logic [10:0] BRGO  = {5'b00000, 3'b110, 2'd1, 1'b0};

  typedef struct {
    logic [6:0] fl;
    logic [4:0] rs1, rs2, rd;
    logic [4:0] es;
    logic [2:0] ef;
    logic [1:0] esel;
  } vec_t;
  vec_t tv[13];

  // model: phase 0 = running, 1 = draining, 2 = redirecting
  int          m_phase;
  int          m_left;
  logic [31:0] m_epc;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic clear_in();
    imem_busy = 0; dmem_busy = 0; id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; ex_memread = 0; ex_br_taken = 0; ex_mret = 0;
    ex_br_target = 0; ifid_pc = 0; irq_pending = 0; mie = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    clear_in();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    m_phase = 0; m_left = 0; m_epc = 0;
  endtask

  task automatic cyc(input logic [10:0] exp, input logic [31:0] eepc, input string nm);
    @(negedge clk);
    chk({nm, " outs"}, {21'd0, obs}, {21'd0, exp});
    chk({nm, " epc"}, trap_epc, eepc);
    @(posedge clk);
    #1;
  endtask

  function automatic logic lu_model();
    return ex_memread && ex_rd != 0 &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
  endfunction

  function automatic logic [10:0] model_out();
    if (rst) return 11'b0;
    if (dmem_busy) return BUSY;
    if (m_phase == 2) return REDIR;
    if (ex_br_taken || ex_mret)
      return imem_busy ? {5'b11100, 3'b001, 2'd0, 1'b0}
                       : {5'b00000, 3'b110, (ex_mret ? 2'd3 : 2'd1), 1'b0};
    if (lu_model()) return {5'b11000, 3'b010, 2'd0, 1'b0};
    if (imem_busy || m_phase == 1) return DRNO;
    return IDLE;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_phase = 0; m_left = 0; m_epc = 0;
    end else if (!dmem_busy) begin
      if (m_phase == 2) m_phase = 0;
      else if (m_phase == 1) begin
        if (ex_br_taken || ex_mret) m_epc = ex_br_target;
        m_left = (m_left > 0) ? m_left - 1 : 0;
        if (m_left == 0) m_phase = 2;
      end else if (irq_pending && mie && !ex_br_taken && !ex_mret && !lu_model()) begin
        m_epc = ifid_pc; m_left = 3; m_phase = 1;
      end
    end
  endtask

  initial begin
    // flags: {imem, dmem, memread, br, mret, use1, use2}
    tv[0]  = '{7'b0000000, 5'd0, 5'd0, 5'd0, 5'b00000, 3'b000, 2'd0};
    tv[1]  = '{7'b0010010, 5'd5, 5'd0, 5'd5, 5'b11000, 3'b010, 2'd0};
    tv[2]  = '{7'b0010010, 5'd0, 5'd0, 5'd0, 5'b00000, 3'b000, 2'd0};
    tv[3]  = '{7'b0010001, 5'd1, 5'd7, 5'd7, 5'b11000, 3'b010, 2'd0};
    tv[4]  = '{7'b0010000, 5'd7, 5'd7, 5'd7, 5'b00000, 3'b000, 2'd0};
    tv[5]  = '{7'b0000011, 5'd7, 5'd7, 5'd7, 5'b00000, 3'b000, 2'd0};
    tv[6]  = '{7'b0001000, 5'd0, 5'd0, 5'd0, 5'b00000, 3'b110, 2'd1};
    tv[7]  = '{7'b0000100, 5'd0, 5'd0, 5'd0, 5'b00000, 3'b110, 2'd3};
    tv[8]  = '{7'b1001000, 5'd0, 5'd0, 5'd0, 5'b11100, 3'b001, 2'd0};
    tv[9]  = '{7'b1000000, 5'd0, 5'd0, 5'd0, 5'b10000, 3'b100, 2'd0};
    tv[10] = '{7'b0111010, 5'd5, 5'd0, 5'd5, 5'b11111, 3'b000, 2'd0};
    tv[11] = '{7'b0011010, 5'd5, 5'd0, 5'd5, 5'b00000, 3'b110, 2'd1};
    tv[12] = '{7'b1010010, 5'd5, 5'd0, 5'd5, 5'b11000, 3'b010, 2'd0};

    rst = 1;
    clear_in();
    dmem_busy = 1; ex_br_taken = 1; irq_pending = 1; mie = 1;
    #3;
    chk("reset outs", {21'd0, obs}, 32'd0);
    chk("reset epc", trap_epc, 32'd0);
    do_reset();

    for (int i = 0; i < 13; i++) begin
      {imem_busy, dmem_busy, ex_memread, ex_br_taken, ex_mret, id_use_rs1, id_use_rs2} = tv[i].fl;
      id_rs1 = tv[i].rs1; id_rs2 = tv[i].rs2; ex_rd = tv[i].rd; ex_br_target = 32'h100;
      cyc({tv[i].es, tv[i].ef, tv[i].esel, 1'b0}, 32'd0, $sformatf("vec%0d", i));
    end

    // interrupt entry: 3 drain cycles, then the trap pulse
    do_reset();
    irq_pending = 1; mie = 1; ifid_pc = 32'h40;
    cyc(IDLE, 32'd0, "irq accept");
    irq_pending = 0; ifid_pc = 32'h44;
    for (int i = 0; i < 3; i++) cyc(DRNO, 32'h40, $sformatf("irq drain%0d", i));
    cyc(REDIR, 32'h40, "irq redirect");
    cyc(IDLE, 32'h40, "irq after");

    // data-memory wait states stretch the drain
    do_reset();
    irq_pending = 1; mie = 1; ifid_pc = 32'h40;
    cyc(IDLE, 32'd0, "busy accept");
    irq_pending = 0;
    cyc(DRNO, 32'h40, "busy drain0");
    dmem_busy = 1;
    cyc(BUSY, 32'h40, "busy hold0");
    cyc(BUSY, 32'h40, "busy hold1");
    dmem_busy = 0;
    cyc(DRNO, 32'h40, "busy drain1");
    cyc(DRNO, 32'h40, "busy drain2");
    cyc(REDIR, 32'h40, "busy redirect");

    // branch resolving in drain replaces the exception PC
    do_reset();
    irq_pending = 1; mie = 1; ifid_pc = 32'h40;
    cyc(IDLE, 32'd0, "brd accept");
    irq_pending = 0; ex_br_taken = 1; ex_br_target = 32'h200;
    cyc(BRGO, 32'h40, "brd branch");
    ex_br_taken = 0;
    cyc(DRNO, 32'h200, "brd drain1");
    cyc(DRNO, 32'h200, "brd drain2");
    cyc(REDIR, 32'h200, "brd redirect");

    // reset mid-drain abandons the entry
    do_reset();
    irq_pending = 1; mie = 1; ifid_pc = 32'h40;
    cyc(IDLE, 32'd0, "rstd accept");
    irq_pending = 0;
    cyc(DRNO, 32'h40, "rstd drain");
    #2 rst = 1;
    #1;
    chk("rstd outs", {21'd0, obs}, 32'd0);
    chk("rstd epc", trap_epc, 32'd0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 5; i++) cyc(IDLE, 32'd0, $sformatf("rstd run%0d", i));

    // randomized run against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 99) == 0);
      imem_busy    = ($urandom_range(0, 3) == 0);
      dmem_busy    = ($urandom_range(0, 7) == 0);
      ex_br_taken  = ($urandom_range(0, 7) == 0);
      ex_mret      = ($urandom_range(0, 15) == 0);
      ex_memread   = ($urandom_range(0, 2) == 0);
      id_use_rs1   = $urandom_range(0, 1) == 1;
      id_use_rs2   = $urandom_range(0, 1) == 1;
      id_rs1       = 5'($urandom_range(0, 3));
      id_rs2       = 5'($urandom_range(0, 3));
      ex_rd        = 5'($urandom_range(0, 3));
      ex_br_target = $urandom & 32'hFFFF_FFFC;
      ifid_pc      = $urandom & 32'hFFFF_FFFC;
      irq_pending  = ($urandom_range(0, 3) == 0);
      mie          = $urandom_range(0, 1) == 1;
      @(negedge clk);
      chk("rand outs", {21'd0, obs}, {21'd0, model_out()});
      chk("rand epc", trap_epc, rst ? 32'd0 : m_epc);
      @(posedge clk);
      model_step();
      #1;
    end
    rst = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
